// File: rtl/fifo_sync_param.sv
// Synchronous single-clock FIFO with binary wrap-bit pointers, level flags,
// sticky overflow/underflow flags and selectable registered or FWFT read.
module fifo_sync_param #(
    parameter int MEMORY_WIDTH    = 8,
    parameter int ADDRESS_SIZE    = 4,
    parameter int ALMOST_FULL_TH  = 2**ADDRESS_SIZE - 2,
    parameter int ALMOST_EMPTY_TH = 2,
    parameter bit FWFT            = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    w_en,
    input  logic [MEMORY_WIDTH-1:0] wdata,
    input  logic                    r_en,
    input  logic                    clr_err,
    output logic [MEMORY_WIDTH-1:0] rdata,
    output logic                    w_full,
    output logic                    r_empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [ADDRESS_SIZE:0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int DEPTH = 2**ADDRESS_SIZE;
    localparam int PTR_W = ADDRESS_SIZE + 1;
    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(ALMOST_FULL_TH);
    localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(ALMOST_EMPTY_TH);

    logic [MEMORY_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [ADDRESS_SIZE-1:0] wr_addr;
    logic [ADDRESS_SIZE-1:0] rd_addr;
    logic                    wr_acc;
    logic                    rd_acc;

    assign wr_addr = wr_ptr[ADDRESS_SIZE-1:0];
    assign rd_addr = rd_ptr[ADDRESS_SIZE-1:0];

    // Flags come from registered pointers only, so acceptance always uses
    // the pre-edge view of full/empty.
    assign r_empty      = (wr_ptr == rd_ptr);
    assign w_full       = (wr_addr == rd_addr) && (wr_ptr[ADDRESS_SIZE] != rd_ptr[ADDRESS_SIZE]);
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign wr_acc = w_en && !w_full;
    assign rd_acc = r_en && !r_empty;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A set condition on the same edge takes priority over clr_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && w_full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (r_en && r_empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign rdata = mem[rd_addr];
        end else begin : g_reg_read
            logic [MEMORY_WIDTH-1:0] rdata_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (rd_acc) begin
                    rdata_q <= mem[rd_addr];
                end
            end

            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: depth-4 FIFO in registered-read and
// FWFT flavours driven by the same directed stimulus.
module tb_fifo_sync_param;

    localparam int MW = 8;
    localparam int AS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_en = 1'b0;
    logic [MW-1:0] wdata = '0;
    logic          r_en = 1'b0;
    logic          clr_err = 1'b0;

    logic [MW-1:0] rdata, rdata_f;
    logic          w_full, r_empty, almost_full, almost_empty, overflow, underflow;
    logic          w_full_f, r_empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;
    logic [AS:0]   count, count_f;

    int n_vec = 0;
    int n_err = 0;

    logic [MW-1:0] mdl[$];
    logic [MW-1:0] exp_q[$];
    logic [MW-1:0] exp_rdata = '0;
    logic          exp_rd_fire = 1'b0;
    logic          exp_of = 1'b0;
    logic          exp_uf = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_param #(.MEMORY_WIDTH(MW), .ADDRESS_SIZE(AS), .ALMOST_FULL_TH(3),
                      .ALMOST_EMPTY_TH(1), .FWFT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .wdata(wdata), .r_en(r_en),
        .clr_err(clr_err), .rdata(rdata), .w_full(w_full), .r_empty(r_empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow));

    fifo_sync_param #(.MEMORY_WIDTH(MW), .ADDRESS_SIZE(AS), .ALMOST_FULL_TH(3),
                      .ALMOST_EMPTY_TH(1), .FWFT(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .wdata(wdata), .r_en(r_en),
        .clr_err(clr_err), .rdata(rdata_f), .w_full(w_full_f), .r_empty(r_empty_f),
        .almost_full(almost_full_f), .almost_empty(almost_empty_f), .count(count_f),
        .overflow(overflow_f), .underflow(underflow_f));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        int n;
        n = mdl.size();
        check("count",        32'(count),        32'(n));
        check("w_full",       32'(w_full),       32'(n == 4));
        check("r_empty",      32'(r_empty),      32'(n == 0));
        check("almost_full",  32'(almost_full),  32'(n >= 3));
        check("almost_empty", 32'(almost_empty), 32'(n <= 1));
        check("overflow",     32'(overflow),     32'(exp_of));
        check("underflow",    32'(underflow),    32'(exp_uf));
        check("count_fwft",   32'(count_f),      32'(n));
        check("flags_fwft",   {28'd0, overflow_f, underflow_f, w_full_f, r_empty_f},
                              {28'd0, exp_of, exp_uf, 1'b0 | (n == 4), 1'b0 | (n == 0)});
    endtask

    // Called at a falling edge: drive one cycle of inputs, model it, check flags.
    task automatic cycle(input logic w, input logic [MW-1:0] d, input logic r, input logic clr);
        logic wa, ra;
        w_en = w; wdata = d; r_en = r; clr_err = clr;
        wa = w && (mdl.size() < 4);
        ra = r && (mdl.size() > 0);
        if (ra) exp_q.push_back(mdl[0]);
        exp_rd_fire = ra;
        exp_of = (w && mdl.size() == 4) ? 1'b1 : (clr ? 1'b0 : exp_of);
        exp_uf = (r && mdl.size() == 0) ? 1'b1 : (clr ? 1'b0 : exp_uf);
        @(posedge clk);
        if (ra) void'(mdl.pop_front());
        if (wa) mdl.push_back(d);
        @(negedge clk);
        exp_rd_fire = 1'b0;
        w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
        check_status();
    endtask

    task automatic check_reset_outputs();
        check("rst_count",   32'(count),        32'd0);
        check("rst_empty",   32'(r_empty),      32'd1);
        check("rst_full",    32'(w_full),       32'd0);
        check("rst_ae_af",   {30'd0, almost_empty, almost_full}, 32'b10);
        check("rst_sticky",  {30'd0, overflow, underflow},       32'd0);
        check("rst_rdata",   32'(rdata),        32'd0);
        check("rst_fwft",    {29'd0, r_empty_f, count_f == 0, overflow_f | underflow_f}, 32'b110);
    endtask

    // Monitor: registered rdata must equal the last popped expectation, and
    // the FWFT copy must present the model head whenever data is stored.
    initial begin
        logic fire;
        forever begin
            @(posedge clk);
            fire = exp_rd_fire;
            @(negedge clk);
            if (fire) begin
                if (exp_q.size() == 0) begin
                    check("sb_underrun", 32'd1, 32'd0);
                end else begin
                    exp_rdata = exp_q.pop_front();
                end
            end
            check("rdata", 32'(rdata), 32'(exp_rdata));
            if (mdl.size() > 0) check("rdata_fwft", 32'(rdata_f), 32'(mdl[0]));
        end
    end

    initial begin
        #2;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill: count 1..4, almost_full at 3, full at 4.
        cycle(1, 8'h11, 0, 0);
        cycle(1, 8'h22, 0, 0);
        cycle(1, 8'h33, 0, 0);
        check("af_at_3", 32'(almost_full), 32'd1);
        cycle(1, 8'h44, 0, 0);
        check("full_at_4", 32'(w_full), 32'd1);
        check("fwft_head_before_read", 32'(rdata_f), 32'h11);

        // Write while full is dropped and flagged.
        cycle(1, 8'hAA, 0, 0);
        check("overflow_set", 32'(overflow), 32'd1);
        check("count_after_ovf", 32'(count), 32'd4);

        // Registered read: 0x11 appears after the edge and is held.
        cycle(0, 8'h00, 1, 0);
        check("first_read", 32'(rdata), 32'h11);
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 0);
        check("rdata_held", 32'(rdata), 32'h11);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 1, 0);
        check("last_read", 32'(rdata), 32'h44);

        // Empty: read rejected while the write lands; set beats clear.
        cycle(1, 8'h55, 1, 0);
        check("underflow_set", 32'(underflow), 32'd1);
        check("count_after_udf", 32'(count), 32'd1);
        check("rdata_kept_on_reject", 32'(rdata), 32'h44);
        cycle(0, 8'h00, 1, 0);
        check("read_55", 32'(rdata), 32'h55);
        cycle(0, 8'h00, 1, 1);
        check("uf_set_wins", {30'd0, overflow, underflow}, 32'b01);
        cycle(0, 8'h00, 0, 1);
        check("sticky_cleared", {30'd0, overflow, underflow}, 32'b00);

        // Steady state at count 2 with simultaneous read and write; pointers wrap.
        cycle(1, 8'hA0, 0, 0);
        cycle(1, 8'hA1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 8'hB0 + 8'(i), 1, 0);
            check("count_steady", 32'(count), 32'd2);
        end
        check("steady_last_read", 32'(rdata), 32'hB3);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);
        check("drain_last", 32'(rdata), 32'hB5);

        // Asynchronous reset mid-burst at count 3.
        cycle(1, 8'hC0, 0, 0);
        cycle(1, 8'hC1, 0, 0);
        cycle(1, 8'hC2, 1, 0);
        cycle(1, 8'hC3, 0, 0);
        check("count_before_rst", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        mdl.delete();
        exp_q.delete();
        exp_rdata = '0;
        exp_of = 1'b0;
        exp_uf = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cycle(1, 8'h77, 0, 0);
        check("fwft_after_rst", 32'(rdata_f), 32'h77);
        cycle(0, 8'h00, 1, 0);
        check("read_after_rst", 32'(rdata), 32'h77);
        cycle(0, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 SHALL have parameter MEMORY_WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter ADDRESS_SIZE, default 4, address bits; depth = 2**ADDRESS_SIZE (ADDRESS_SIZE >= 1).
REQ-003 SHALL have parameter ALMOST_FULL_TH, default 2**ADDRESS_SIZE-2, level at or above which almost_full asserts.
REQ-004 SHALL have parameter ALMOST_EMPTY_TH, default 2, level at or below which almost_empty asserts.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- w_en  in  1  write request.
- wdata  in  MEMORY_WIDTH  write data.
- r_en  in  1  read/pop request.
- clr_err  in  1  synchronous clear of sticky error flags.
- rdata  out  MEMORY_WIDTH  read data.
- w_full  out  1  FIFO full.
- r_empty  out  1  FIFO empty.
- almost_full  out  1  level >= ALMOST_FULL_TH.
- almost_empty  out  1  level <= ALMOST_EMPTY_TH.
- count  out  ADDRESS_SIZE+1  current fill level, 0..depth.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Function
REQ-007 SHALL hold storage in a MEMORY_WIDTH x depth register array; storage contents not reset.
REQ-008 SHALL keep binary write and read pointers of ADDRESS_SIZE+1 bits; low ADDRESS_SIZE bits address memory, MSB is wrap bit; pointers wrap naturally modulo 2**(ADDRESS_SIZE+1).
REQ-009 SHALL accept a write iff w_en=1 and w_full=0 at the clock edge; accepted write stores wdata at write address and increments write pointer.
REQ-010 SHALL accept a read iff r_en=1 and r_empty=0 at the clock edge; accepted read increments read pointer.
REQ-011 SHALL evaluate acceptance from flags before the edge: write while full rejected even with simultaneous accepted read; read while empty rejected even with simultaneous write.
REQ-012 SHALL, on simultaneous accepted read and write, update both pointers and leave count unchanged.
REQ-013 SHALL assert r_empty when pointers are equal, w_full when low bits equal and MSBs differ; count = write pointer - read pointer (ADDRESS_SIZE+1 bits).
REQ-014 SHALL derive w_full, r_empty, almost_full, almost_empty, count combinationally from registered pointers only, so they reflect an accepted operation in the cycle after its edge.
REQ-015 SHALL, with FWFT=0, load rdata from the read address on the edge of an accepted read (1-cycle latency) and hold rdata otherwise, including on rejected reads.
REQ-016 SHALL, with FWFT=1, drive rdata combinationally with the word at the read address; valid whenever r_empty=0; accepted read advances to the next word in the following cycle; value while empty is don't-care.
REQ-017 SHALL set overflow on any edge with w_en=1 and w_full=1, and underflow on any edge with r_en=1 and r_empty=1.
REQ-018 SHALL clear overflow and underflow on an edge with clr_err=1; a simultaneous set condition wins over clr_err.
REQ-019 SHALL not change pointers, memory, or rdata on rejected operations.

Reset
REQ-020 SHALL, while rst_n=0, immediately force both pointers to 0, overflow=0, underflow=0, registered rdata (FWFT=0) to 0, hence r_empty=1, w_full=0, count=0, almost_empty=1, almost_full=0.
REQ-021 SHALL discard all stored data on reset asserted mid-operation; first write after rst_n deasserts lands at address 0.

Verification (ADDRESS_SIZE=2, depth 4, MEMORY_WIDTH=8, ALMOST_FULL_TH=3, ALMOST_EMPTY_TH=1)
REQ-022 SHALL verify: reset, then write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_full at count 3; w_full=1 after 4th write.
REQ-023 SHALL verify: full, w_en=1 wdata=0xAA -> write rejected, overflow=1, count stays 4; later reads return 0x11,0x22,0x33,0x44 (0xAA never appears).
REQ-024 SHALL verify FWFT=0: read from full -> rdata=0x11 one cycle after the r_en edge, held while r_en=0; FWFT=1: rdata=0x11 before any r_en.
REQ-025 SHALL verify: count=2, r_en=1 and w_en=1 for 6 cycles -> count stays 2, pointers wrap past 7->0, data order preserved.
REQ-026 SHALL verify: empty, r_en=1 with w_en=1 wdata=0x55 -> read rejected, underflow=1, count=1; next read returns 0x55; clr_err=1 -> both sticky flags 0.
REQ-027 SHALL verify: rst_n pulsed low mid-burst at count=3 -> outputs at reset values without a clock edge; next write/read pair returns newly written data.
